// File: rtl/readback_bram_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : readback_bram_controller_pkg
// Description : Shared defaults and width helpers for the readback return path
//               (DDR read data -> readback BRAM -> host stream).
// Revision    : 1.0 - initial release
// ============================================================================
package readback_bram_controller_pkg;

    // Default BRAM address width (DEPTH = 2**RDBACK_ADDR_W entries)
    localparam int RDBACK_ADDR_W      = 10;
    // Default beat width, matches the DDR app read-data bus
    localparam int RDBACK_DATA_W      = 256;
    // Beats returned by the DRAM for every READ command issued
    localparam int RDBACK_BURST_BEATS = 2;

    // Occupancy and pending counters must be able to represent DEPTH itself,
    // so they carry one bit more than the BRAM address.
    function automatic int occ_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rdback_out_skid.sv
`default_nettype none
// ============================================================================
// Module      : rdback_out_skid
// Description : Two-entry valid/ready output stage fed by a BRAM read port
//               with one cycle of read latency. It tracks the read that is
//               in flight and tells the producer when another read may be
//               launched without overrunning the two entries.
// Revision    : 1.0 - initial release
// ============================================================================
module rdback_out_skid #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] rd_data,
    output logic              can_issue,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_head;
    logic [1:0]        r_cnt;
    logic              r_inflight;

    logic              w_pop;
    logic              w_push;
    logic              w_wr_idx;
    logic [2:0]        w_slots;

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem[r_head];
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_inflight;
    // New beat lands right behind the oldest held entry
    assign w_wr_idx  = r_head ^ r_cnt[0];

    // Entries committed after this edge: held + arriving - leaving. Counting
    // the slot freed by a pop keeps the stream at one beat per cycle.
    assign w_slots   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign can_issue = (w_slots < 3'd2);

    // Control state: in-flight tag, head pointer and entry count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_cnt      <= 2'd0;
        end else if (flush) begin
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_inflight <= rd_issue;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Data entries: capture the BRAM output the cycle after the read
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[w_wr_idx] <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/readback_bram_controller.sv
`default_nettype none
// ============================================================================
// Module      : readback_bram_controller
// Description : Captures DDR read-data beats into a readback BRAM, streams
//               them to the host over valid/ready, grants READ-issue credit
//               so returning data always has reserved space, and flags
//               program completion once everything has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module readback_bram_controller
    import readback_bram_controller_pkg::*;
#(
    parameter int WIDTH       = RDBACK_ADDR_W,
    parameter int DATA_W      = RDBACK_DATA_W,
    parameter int BURST_BEATS = RDBACK_BURST_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              rd_issue,
    output logic              credit_ok,
    input  logic              ddr_valid,
    input  logic [DATA_W-1:0] ddr_data,
    input  logic              prog_end,
    output logic              bram_we,
    output logic [WIDTH-1:0]  bram_waddr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              bram_re,
    output logic [WIDTH-1:0]  bram_raddr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    localparam int                 c_occ_w = occ_width(WIDTH);
    localparam int                 c_depth = 2 ** WIDTH;
    localparam logic [c_occ_w-1:0] c_full  = c_occ_w'(c_depth);
    localparam logic [c_occ_w-1:0] c_burst = c_occ_w'(BURST_BEATS);

    logic [WIDTH-1:0]   r_wr_ptr;
    logic [WIDTH-1:0]   r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;       // written and not yet popped by host
    logic [c_occ_w-1:0] r_unread;    // still in BRAM, not yet read out
    logic [c_occ_w-1:0] r_pending;   // beats owed by issued READs
    logic               r_end;
    logic               r_err;

    logic               w_full;
    logic               w_wr_ok;
    logic               w_drop;
    logic               w_unexpected;
    logic               w_pend_dec;
    logic               w_pop;
    logic               w_can_issue;
    logic [c_occ_w+1:0] w_credit_sum;

    // A flushed cycle ignores every event so nothing leaks into the cleared state
    assign w_full       = (r_occ == c_full);
    assign w_wr_ok      = ddr_valid & ~w_full & ~flush;
    assign w_drop       = ddr_valid &  w_full & ~flush;
    // A beat arriving alongside a fresh issue consumes that issue's credit
    assign w_unexpected = ddr_valid & (r_pending == '0) & ~rd_issue & ~flush;
    assign w_pend_dec   = ddr_valid & ((r_pending != '0) | rd_issue);
    assign w_pop        = out_valid & out_ready & ~flush;

    assign bram_we    = w_wr_ok;
    assign bram_waddr = r_wr_ptr;
    assign bram_wdata = ddr_data;

    // Only beats committed at an earlier edge are readable, so a beat is
    // never read in the cycle it is written.
    assign bram_re    = (r_unread != '0) & w_can_issue & ~flush;
    assign bram_raddr = r_rd_ptr;

    assign w_credit_sum = {2'b00, r_occ} + {2'b00, r_pending}
                        + (c_occ_w + 2)'(BURST_BEATS);
    assign credit_ok    = (w_credit_sum <= (c_occ_w + 2)'(c_depth));

    assign done = r_end & (r_pending == '0) & (r_occ == '0);
    assign err  = r_err;

    // Pointers and occupancy / pending bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_unread  <= '0;
            r_pending <= '0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_unread  <= '0;
            r_pending <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (bram_re) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ     <= r_occ + c_occ_w'(w_wr_ok) - c_occ_w'(w_pop);
            r_unread  <= r_unread + c_occ_w'(w_wr_ok) - c_occ_w'(bram_re);
            r_pending <= r_pending + (rd_issue ? c_burst : '0)
                       - c_occ_w'(w_pend_dec);
        end
    end

    // End-of-program latch, released only by flush or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end <= 1'b0;
        end else if (flush) begin
            r_end <= 1'b0;
        end else if (prog_end) begin
            r_end <= 1'b1;
        end
    end

    // Sticky error: overflow or a beat nobody asked for; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_drop || w_unexpected) begin
            r_err <= 1'b1;
        end
    end

    rdback_out_skid #(
        .DATA_W (DATA_W)
    ) u_out_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rd_issue  (bram_re),
        .rd_data   (bram_rdata),
        .can_issue (w_can_issue),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_readback_bram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_readback_bram_controller
// Description : Self-checking bench: a queue-based model of the readback
//               buffer checked every cycle, plus directed literal checks for
//               latency, ordering, credit, overflow, flush and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readback_bram_controller;

    localparam int WIDTH  = 4;
    localparam int DATA_W = 16;
    localparam int BURST  = 2;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              rd_issue;
    logic              credit_ok;
    logic              ddr_valid;
    logic [DATA_W-1:0] ddr_data;
    logic              prog_end;
    logic              bram_we;
    logic [WIDTH-1:0]  bram_waddr;
    logic [DATA_W-1:0] bram_wdata;
    logic              bram_re;
    logic [WIDTH-1:0]  bram_raddr;
    logic [DATA_W-1:0] bram_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              done;
    logic              err;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pops = 0;

    readback_bram_controller #(
        .WIDTH       (WIDTH),
        .DATA_W      (DATA_W),
        .BURST_BEATS (BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .rd_issue   (rd_issue),
        .credit_ok  (credit_ok),
        .ddr_valid  (ddr_valid),
        .ddr_data   (ddr_data),
        .prog_end   (prog_end),
        .bram_we    (bram_we),
        .bram_waddr (bram_waddr),
        .bram_wdata (bram_wdata),
        .bram_re    (bram_re),
        .bram_raddr (bram_raddr),
        .bram_rdata (bram_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Simple dual-port BRAM with one cycle read latency
    logic [DATA_W-1:0] bram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bram_re) bram_rdata <= bram_mem[bram_raddr];
        if (bram_we) bram_mem[bram_waddr] <= bram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_q[$];   // beats held by the controller, oldest first
    int                m_pend;
    bit                m_err;
    bit                m_end;
    bit                pop_flag;

    always @(posedge clk or negedge rst_n) begin : p_model
        int sz;
        if (!rst_n) begin
            m_q.delete();
            m_pend = 0;
            m_err  = 0;
            m_end  = 0;
        end else if (flush) begin
            m_q.delete();
            m_pend = 0;
            m_end  = 0;
        end else begin
            sz = m_q.size();
            if (pop_flag) void'(m_q.pop_front());
            if (ddr_valid) begin
                if (sz < DEPTH) m_q.push_back(ddr_data);
                else            m_err = 1;
                if (m_pend == 0 && !rd_issue) m_err = 1;
            end
            m_pend = m_pend + (rd_issue ? BURST : 0)
                   - ((ddr_valid && (m_pend != 0 || rd_issue)) ? 1 : 0);
            if (prog_end) m_end = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data;

    always @(negedge clk) begin
        pop_flag = 0;
        check("credit_ok", {31'd0, credit_ok}, {31'd0, (m_q.size() + m_pend + BURST) <= DEPTH});
        check("done", {31'd0, done}, {31'd0, m_end && m_pend == 0 && m_q.size() == 0});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("bram_we", {31'd0, bram_we}, {31'd0, ddr_valid && !flush && m_q.size() < DEPTH});
        if (out_valid) begin
            check("out_valid_has_beat", {31'd0, m_q.size() != 0}, 32'd1);
            if (m_q.size() != 0) check("out_data_order", {16'd0, out_data}, {16'd0, m_q[0]});
            if (prev_stall) check("out_data_hold", {16'd0, out_data}, {16'd0, prev_data});
            if (out_ready && m_q.size() != 0) begin
                pop_flag = 1;
                n_pops++;
            end
        end
        prev_stall = rst_n && !flush && out_valid && !out_ready;
        prev_data  = out_data;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            rd_issue = 1'b1;
            tick();
        end
        rd_issue = 1'b0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d);
        ddr_valid = 1'b1;
        ddr_data  = d;
        tick();
        ddr_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        i = 0;
        while ((m_q.size() != 0 || out_valid) && i < 200) begin
            tick();
            i++;
        end
        check("drain_bounded", {31'd0, m_q.size() == 0 && !out_valid}, 32'd1);
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int p0;
        rst_n = 1'b0; flush = 1'b0; rd_issue = 1'b0; ddr_valid = 1'b0;
        ddr_data = '0; prog_end = 1'b0; out_ready = 1'b0;
        #2;
        // Reset values
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bram_we", {31'd0, bram_we}, 32'd0);
        check("rst_bram_re", {31'd0, bram_re}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_credit", {31'd0, credit_ok}, 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Latency: sampled at E0, read during following cycle, visible after E2
        issue(1);
        beat(16'h0011);                       // E0
        check("lat_bram_re", {31'd0, bram_re}, 32'd1);
        check("lat_e0_valid", {31'd0, out_valid}, 32'd0);
        tick();                               // E1
        check("lat_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();                               // E2
        check("lat_e2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_e2_data", {16'd0, out_data}, 32'h0011);
        beat(16'h0012);
        drain();

        // Single burst with host always ready
        out_ready = 1'b1;
        issue(1);
        beat(16'h00A0);
        beat(16'h00A1);
        tick();
        check("burst_first", {16'd0, out_data}, 32'h00A0);
        tick();
        check("burst_second", {16'd0, out_data}, 32'h00A1);
        check("burst_second_v", {31'd0, out_valid}, 32'd1);
        tick();
        check("burst_empty", {31'd0, out_valid}, 32'd0);
        prog_end = 1'b1;
        tick();
        prog_end = 1'b0;
        check("burst_done", {31'd0, done}, 32'd1);
        tick();
        check("burst_done_held", {31'd0, done}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("burst_done_flushed", {31'd0, done}, 32'd0);

        // Back-pressure: 8 beats, host stalled for cycles 3..12
        out_ready = 1'b1;
        issue(4);
        p0 = n_pops;
        for (int c = 0; c < 13; c++) begin
            ddr_valid = (c < 8);
            ddr_data  = 16'h0030 + 16'(c);
            out_ready = !(c >= 3 && c <= 12);
            tick();
        end
        ddr_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_no_early_pop", n_pops - p0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("bp_full_rate", {31'd0, out_valid}, 32'd1);
            tick();
        end
        check("bp_after_stream", {31'd0, out_valid}, 32'd0);
        check("bp_pop_count", n_pops - p0, 32'd8);

        // Credit: DEPTH=16, 2 beats per READ
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rd_issue = 1'b1;
            tick();
            rd_issue = 1'b0;
            if (i == 7) check("credit_after_7", {31'd0, credit_ok}, 32'd1);
            if (i == 8) check("credit_after_8", {31'd0, credit_ok}, 32'd0);
        end
        for (int i = 0; i < 16; i++) beat(16'h0040 + 16'(i));
        tick();
        check("credit_full", {31'd0, credit_ok}, 32'd0);
        check("credit_no_err", {31'd0, err}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("credit_one_pop", {31'd0, credit_ok}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("credit_two_pops", {31'd0, credit_ok}, 32'd1);
        drain();

        // Overflow and pointer wrap
        out_ready = 1'b0;
        issue(8);
        for (int i = 0; i < 17; i++) beat(16'h0060 + 16'(i));
        check("ovf_err", {31'd0, err}, 32'd1);
        p0 = n_pops;
        drain();
        check("ovf_stored", n_pops - p0, 32'd16);
        issue(10);
        for (int i = 0; i < 20; i++) beat(16'h0080 + 16'(i));
        drain();
        check("wrap_count", n_pops - p0, 32'd36);

        // Flush with 5 beats buffered
        out_ready = 1'b0;
        issue(3);
        for (int i = 0; i < 5; i++) beat(16'h0090 + 16'(i));
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_credit", {31'd0, credit_ok}, 32'd1);
        check("flush_err_kept", {31'd0, err}, 32'd1);
        out_ready = 1'b1;
        issue(1);
        beat(16'h0055);
        tick();
        check("flush_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("flush_new_valid", {31'd0, out_valid}, 32'd1);
        check("flush_new_data", {16'd0, out_data}, 32'h0055);
        beat(16'h0056);
        drain();

        // Reset in the middle of traffic
        out_ready = 1'b1;
        issue(2);
        ddr_valid = 1'b1; ddr_data = 16'h00C0; tick();
        ddr_data = 16'h00C1; tick();
        ddr_data = 16'h00C2; tick();
        rst_n = 1'b0;
        ddr_valid = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_credit", {31'd0, credit_ok}, 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        issue(1);
        beat(16'h0077);
        tick();
        check("post_rst_e1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_data", {16'd0, out_data}, 32'h0077);
        beat(16'h0078);
        drain();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
